// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - shared states, command field constants and default bit timing for the UART register bridge
package uart_bridge_pkg;

  typedef enum logic [1:0] {
    CMD_WAIT,
    DATA_WAIT,
    RD_WAIT,
    TX
  } parser_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam int          CMD_WR_BIT           = 7;
  localparam logic [7:0]  CMD_RSVD_MASK        = 8'h70;
  localparam int          DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 receiver: input synchronizer, bit timer and deserializer
// byte_valid / frame_err are single-cycle strobes in the stop-bit sample cycle.
module uart_rx_core
  import uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam logic [7:0] HALF_BIT = 8'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] FULL_BIT = 8'(CLKS_PER_BIT - 1);

  logic       rx_s1;
  logic       rx_s2;
  logic       rx_prev;
  rx_state_t  state;
  logic [7:0] cnt;
  logic [2:0] bit_idx;
  logic       stop_sample;

  assign stop_sample = (state == RX_STOP) && (cnt == FULL_BIT);
  assign byte_valid  = stop_sample && rx_s2;
  assign frame_err   = stop_sample && !rx_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      byte_data <= '0;
    end else begin
      rx_s1   <= rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          // A line that is high again at mid start bit was a glitch.
          if (cnt == HALF_BIT) begin
            state   <= rx_s2 ? RX_IDLE : RX_DATA;
            cnt     <= '0;
            bit_idx <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_BIT) begin
            cnt       <= '0;
            byte_data <= {rx_s2, byte_data[7:1]};
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_BIT) begin
            state <= RX_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_reg_bridge.sv
// rtl/uart_reg_bridge.sv - UART command parser driving a register write port, with inline readback transmitter
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_i,
  output logic              tx_o,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              frame_err
);

  localparam logic [7:0] FULL_BIT = 8'(CLKS_PER_BIT - 1);

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_frame_err;

  parser_state_t     state;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_phase;
  logic [DATA_W:0]   tx_shift;
  logic [7:0]        tx_cnt;
  logic [3:0]        tx_bit;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx_i),
    .byte_valid(rx_valid),
    .byte_data (rx_data),
    .frame_err (rx_frame_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CMD_WAIT;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      tx_o      <= 1'b1;
      wr_addr   <= '0;
      rd_phase  <= 1'b0;
      tx_shift  <= '0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
    end else begin
      reg_we    <= 1'b0;
      frame_err <= rx_frame_err;
      case (state)
        CMD_WAIT: begin
          if (rx_valid && ((rx_data & CMD_RSVD_MASK) == 8'h00)) begin
            if (rx_data[CMD_WR_BIT]) begin
              wr_addr <= rx_data[ADDR_W-1:0];
              state   <= DATA_WAIT;
            end else begin
              reg_addr <= rx_data[ADDR_W-1:0];
              rd_phase <= 1'b0;
              busy     <= 1'b1;
              state    <= RD_WAIT;
            end
          end
        end
        DATA_WAIT: begin
          if (rx_frame_err) begin
            state <= CMD_WAIT;
          end else if (rx_valid) begin
            reg_addr  <= wr_addr;
            reg_wdata <= rx_data;
            reg_we    <= 1'b1;
            state     <= CMD_WAIT;
          end
        end
        RD_WAIT: begin
          // One spare cycle so a registered read has settled before capture.
          if (!rd_phase) begin
            rd_phase <= 1'b1;
          end else begin
            tx_shift <= {1'b1, reg_rdata};
            tx_o     <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            state    <= TX;
          end
        end
        TX: begin
          if (tx_cnt == FULL_BIT) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
              busy  <= 1'b0;
              state <= CMD_WAIT;
            end else begin
              tx_o     <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[DATA_W:1]};
              tx_bit   <= tx_bit + 4'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + 8'd1;
          end
        end
        default: state <= CMD_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb/tb_uart_reg_bridge.sv - scoreboard bench: reference model queues expected writes, frame errors and read responses
module tb_uart_reg_bridge;

  localparam int CPB = 16;
  localparam int RX_LAT = 2 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic       tx_o;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic       frame_err;

  uart_reg_bridge #(.CLKS_PER_BIT(CPB), .ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .tx_o(tx_o), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_rdata(reg_rdata),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register block stand-in with a registered read port.
  logic [7:0] rom [16];
  always @(posedge clk) reg_rdata <= rom[reg_addr];

  typedef struct { logic [3:0] addr; logic [7:0] data; int at; } wr_t;
  typedef struct { logic [7:0] data; int at; } tx_t;
  wr_t exp_wr[$];
  tx_t exp_tx[$];
  int  exp_fe[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: what the parser is waiting for and when its response ends.
  bit         m_pend_wr = 0;
  logic [3:0] m_pend_addr = 0;
  logic [3:0] m_addr = 0;
  logic [7:0] m_wdata = 0;
  int         m_busy_last = -1000;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_near(input string name, input int got, input int exp);
    n_cmp++;
    if (got < exp - 1 || got > exp + 1) begin
      n_err++;
      $display("FAIL %s: got cycle %0d expected cycle %0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] b, input bit stop, input int gap);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = stop;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit stop, input int gap);
    int t;
    t = cyc + RX_LAT;
    if (!stop) begin
      exp_fe.push_back(t + 1);
      m_pend_wr = 0;
    end else if (t > m_busy_last) begin
      if (m_pend_wr) begin
        exp_wr.push_back('{m_pend_addr, b, t + 1});
        m_addr    = m_pend_addr;
        m_wdata   = b;
        m_pend_wr = 0;
      end else if ((b & 8'h70) == 8'h00) begin
        if (b[7]) begin
          m_pend_wr   = 1;
          m_pend_addr = b[3:0];
        end else begin
          m_addr = b[3:0];
          exp_tx.push_back('{rom[b[3:0]], t + 3});
          m_busy_last = t + 2 + 10 * CPB;
        end
      end
    end
    drive(b, stop, gap);
  endtask

  task automatic quiet();
    while (cyc <= m_busy_last + 2) @(negedge clk);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tx_o"}, int'(tx_o), 1);
    check({tag, "_reg_addr"}, int'(reg_addr), 0);
    check({tag, "_reg_wdata"}, int'(reg_wdata), 0);
    check({tag, "_reg_we"}, int'(reg_we), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
  endtask

  // Write / frame-error monitor.
  initial begin
    wr_t w;
    int  f;
    forever begin
      @(negedge clk);
      if (!rst && reg_we) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_reg_we", 1, 0);
        end else begin
          w = exp_wr.pop_front();
          check("wr_addr", int'(reg_addr), int'(w.addr));
          check("wr_data", int'(reg_wdata), int'(w.data));
          check_near("wr_cycle", cyc, w.at);
        end
      end
      if (!rst && frame_err) begin
        if (exp_fe.size() == 0) begin
          check("unexpected_frame_err", 1, 0);
        end else begin
          f = exp_fe.pop_front();
          check_near("fe_cycle", cyc, f);
        end
      end
    end
  end

  // Transmit monitor: decodes each response frame at mid-bit.
  initial begin
    logic       tx_prev;
    tx_t        e;
    int         start_c;
    logic [7:0] got;
    tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && tx_prev && !tx_o) begin
        start_c = cyc;
        if (exp_tx.size() == 0) begin
          check("unexpected_tx", 1, 0);
          e = '{8'h00, start_c};
        end else begin
          e = exp_tx.pop_front();
          check_near("tx_start_cycle", start_c, e.at);
        end
        repeat (CPB / 2) @(negedge clk);
        check("tx_start_bit", int'(tx_o), 0);
        check("tx_busy_start", int'(busy), 1);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          got[i] = tx_o;
        end
        check("tx_data", int'(got), int'(e.data));
        repeat (CPB) @(negedge clk);
        check("tx_stop_bit", int'(tx_o), 1);
        repeat (CPB / 2 - 1) @(negedge clk);
        check("tx_busy_last", int'(busy), 1);
        @(negedge clk);
        check("tx_busy_fall", int'(busy), 0);
      end
      tx_prev = tx_o;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] b;
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    rom[5] = 8'hA5;

    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    send(8'h83, 1, 3);
    send(8'h5A, 1, 3);
    quiet();
    check("tx_idle_after_write", int'(tx_o), 1);

    send(8'h05, 1, 3);
    quiet();
    check("read_addr_hold", int'(reg_addr), 5);

    send(8'h87, 1, 4);
    send(8'hC3, 0, 4);
    send(8'h81, 1, 4);
    send(8'h11, 1, 4);
    quiet();

    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    rx_i = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_addr", int'(reg_addr), int'(m_addr));
    check("glitch_wdata", int'(reg_wdata), int'(m_wdata));
    send(8'h8C, 1, 2);
    send(8'hE7, 1, 2);
    quiet();

    send(8'h93, 1, 2);
    send(8'h82, 1, 2);
    send(8'h66, 1, 2);
    quiet();

    // Bytes landing inside, on the last cycle of, and just after a response.
    send(8'h02, 1, 1);
    send(8'h82, 1, 2);
    send(8'h5A, 1, 2);
    quiet();
    send(8'h03, 1, 2);
    send(8'h81, 1, 2);
    send(8'h22, 1, 2);
    quiet();
    send(8'h04, 1, 3);
    send(8'h86, 1, 2);
    send(8'h77, 1, 2);
    quiet();

    send(8'h89, 1, 3);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    b = 8'hCC;
    for (int i = 0; i < 3; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("midframe");
    m_pend_wr = 0;
    m_addr = 0;
    m_wdata = 0;
    m_busy_last = -1000;
    rx_i = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check("post_reset_addr", int'(reg_addr), 0);
    send(8'h84, 1, 3);
    send(8'h3C, 1, 3);
    quiet();

    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      send(8'h80 | 8'($urandom_range(0, 15)), 1, $urandom_range(1, 20));
      else if (r < 5) send(8'($urandom_range(0, 15)), 1, $urandom_range(1, 20));
      else if (r < 9) send(8'($urandom), 1, $urandom_range(1, 20));
      else            send(8'($urandom), 0, $urandom_range(1, 20));
    end
    quiet();
    repeat (4 * CPB) @(negedge clk);

    check("left_wr", exp_wr.size(), 0);
    check("left_tx", exp_tx.size(), 0);
    check("left_fe", exp_fe.size(), 0);
    check("final_addr", int'(reg_addr), int'(m_addr));
    check("final_wdata", int'(reg_wdata), int'(m_wdata));
    check("final_busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Serial-to-register bridge. It decodes 8N1 UART command frames from a host pin and drives the write port of the GPIO register block: address, write data and a one-cycle write strobe. It also returns register readback over a UART transmit line. It sits directly upstream of `gpio_reg` in the TinyTapeout top and supplies the `cpu_wdata`/`cpu_wen`/address signals, taking `rdata_out` back.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; legal range 4..255, and must be even.
- `ADDR_W`, default 4: register address width.
- `DATA_W`, default 8: data width; fixed by framing and must equal 8.

- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_i`  in  1  UART receive, idle high; asynchronous to `clk`.
- `tx_o`  out  1  UART transmit, idle high.
- `reg_addr`  out  ADDR_W  register address to `gpio_reg`.
- `reg_wdata`  out  8  write data.
- `reg_we`  out  1  write strobe, one-cycle pulse.
- `reg_rdata`  in  8  readback data from `gpio_reg`.
- `busy`  out  1  high while a read response is pending or transmitting.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit.

## Operation
- **Reset values:** `tx_o`=1, `reg_addr`=0, `reg_wdata`=0, `reg_we`=0, `busy`=0, `frame_err`=0. The receiver goes to IDLE and the parser to CMD_WAIT.
- **RX input:** `rx_i` passes through a 2-flop synchronizer before any use.
- **RX states:** IDLE → START → DATA → STOP → IDLE.
- **Start detection:** a falling edge of the synchronized rx in IDLE enters START.
- **START check:** sample at `CLKS_PER_BIT/2` cycles. If the line is high, treat it as a false start and return to IDLE with no event.
- **Data bits:** 8 bits, LSB first, each sampled `CLKS_PER_BIT` cycles after the previous sample.
- **STOP check:** sample one bit period after the last data bit.
  - Stop=1: issue an internal byte-valid pulse with the byte.
  - Stop=0: pulse `frame_err`, discard the byte, and reset the parser to CMD_WAIT.
- **Parser states:** CMD_WAIT, DATA_WAIT, RD_WAIT, TX.
- **Command byte format:** bit7 = 1 for write, 0 for read; bits6:4 must be 000; bits3:0 are the address.
  - Bits6:4 nonzero: ignore the byte and stay in CMD_WAIT.
- **Write command:** latch the address and go to DATA_WAIT. The next valid byte is the data: latch it into `reg_wdata`, pulse `reg_we`, and return to CMD_WAIT.
- **Read command:** drive `reg_addr`, go to RD_WAIT, then capture `reg_rdata` and go to TX.
- **TX:** send 0 (start bit), 8 data bits LSB first, then 1 (stop bit), each held `CLKS_PER_BIT` cycles. Then return to CMD_WAIT.
- **Busy period:** `busy` is 1 in RD_WAIT and TX.
  - The receiver keeps running, but bytes completed while `busy`=1 are dropped silently.
- **Output hold:** `reg_addr` and `reg_wdata` hold their values until changed by a later command.
- **Errors in DATA_WAIT:** a frame error returns the parser to CMD_WAIT with no write. A following byte is parsed as a new command.

## Timing
- **Reference point:** let T be the cycle in which the stop bit is sampled valid.
- **Write:** `reg_we`=1 in exactly cycle T+1, with `reg_addr`/`reg_wdata` already stable in that cycle. It is never high for two consecutive cycles.
- **Read:**
  - `reg_addr` updates at T+1.
  - `reg_rdata` is captured on the edge ending cycle T+2, which allows a registered read.
  - `tx_o` goes low (start bit) at T+3.
  - `busy` rises at T+1 and falls in the cycle after the stop bit's last cycle.
- **`frame_err`:** high in cycle T+1 relative to the bad stop-bit sample.
- **Receive latency:** start edge at `rx_i` to T is 2 synchronizer cycles + 9.5 bit periods (±1 cycle).
- **Reset mid-frame:** takes effect immediately and asynchronously, with no `reg_we` and `tx_o` forced high. After release, the first falling edge starts a fresh frame.
- **Simultaneous events:** a byte-valid in the same cycle TX finishes is dropped, because `busy` is still 1.

## Structure
- **Package `uart_bridge_pkg`:** holds
  - the parser state enum,
  - the RX state enum,
  - `CMD_WR_BIT`=7,
  - the reserved-field mask 8'h70,
  - the default `CLKS_PER_BIT`.
- **Sub-module `uart_rx_core`:** synchronizer, bit timer and deserializer. Outputs `byte_valid`, `byte_data` and `frame_err`.
- **Top of block:** parser FSM and TX shifter live at the top of `uart_reg_bridge`. The TX is small enough to stay inline.

## Test plan
- **Write:** with `CLKS_PER_BIT`=16, send 0x83 then 0x5A → exactly one `reg_we` pulse at T+1 with `reg_addr`=3 and `reg_wdata`=0x5A. `tx_o` stays high.
- **Read:** send 0x05 with `reg_rdata`=0xA5 → `reg_addr`=5 and the `tx_o` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles long, starting at T+3. `busy` covers the response.
- **Bad stop bit:** send a write command, then a data byte with stop=0 → one `frame_err` pulse and no `reg_we`. A following 0x81,0x11 writes 0x11 to address 1.
- **False start:** a 4-cycle low glitch on `rx_i` → no `byte_valid`, no `frame_err` and no outputs change. A following valid frame decodes correctly.
- **Reserved bits and busy drop:** command 0x93 is ignored (the next byte 0x82 is parsed as a command). A write sent during an active read response is dropped, with no `reg_we`.
- **Reset mid-frame:** assert `rst` during the data bits of a write data byte → outputs are at reset values immediately and no write occurs. After release, a full write frame works.
